// File: rtl/bit_serial_alu_ctrl.sv
// Bit-serial ALU sequencer: drives an external 1-bit ALU slice LSB first and assembles result/flags.
// Optional SLT support (alu_ctl=0111) is enabled by defining BSALU_SLT_EN.
module bit_serial_alu_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       alu_ctl,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry_out,
  output logic             overflow,
  output logic             alu_a,
  output logic             alu_b,
  output logic             alu_ainvert,
  output logic             alu_binvert,
  output logic             alu_cin,
  output logic [1:0]       alu_op,
  input  logic             alu_result,
  input  logic             alu_cout
);

  localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       ctl_q, ctl_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic             zero_q, zero_d, cout_q, cout_d, ovf_q, ovf_d;

  logic             run, is_slt, is_addsub, msb_ovf, slt_bit;
  logic [1:0]       op_eff;
  logic [WIDTH-1:0] res_shift;

  function automatic logic is_supported(input logic [3:0] c);
    case (c)
      4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b1100: return 1'b1;
`ifdef BSALU_SLT_EN
      4'b0111: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

`ifdef BSALU_SLT_EN
  assign is_slt = (ctl_q == 4'b0111);
`else
  assign is_slt = 1'b0;
`endif

  assign run       = (state_q == S_RUN);
  assign is_addsub = (ctl_q == 4'b0010) || (ctl_q == 4'b0110);
  // SLT runs on the slice as a plain subtract; the controller forms the less-than bit itself
  assign op_eff    = is_slt ? 2'b10 : ctl_q[1:0];
  assign res_shift = {alu_result, result_q[WIDTH-1:1]};
  assign msb_ovf   = carry_q ^ alu_cout;
  assign slt_bit   = alu_result ^ msb_ovf;

  // Slice drive: only active while running
  assign alu_a       = run & a_sh_q[0];
  assign alu_b       = run & b_sh_q[0];
  assign alu_cin     = run & carry_q;
  assign alu_ainvert = run & ctl_q[3];
  assign alu_binvert = run & ctl_q[2];
  assign alu_op      = run ? op_eff : 2'b00;

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      result_q <= '0;
      ctl_q    <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      zero_q   <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      result_q <= result_d;
      ctl_q    <= ctl_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      zero_q   <= zero_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    result_d = result_q;
    ctl_d    = ctl_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = err_q;
    zero_d   = zero_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (is_supported(alu_ctl)) begin
            a_sh_d  = opa;
            b_sh_d  = opb;
            ctl_d   = alu_ctl;
            carry_d = alu_ctl[2];
            cnt_d   = '0;
            busy_d  = 1'b1;
            err_d   = 1'b0;
            state_d = S_RUN;
          end else begin
            done_d   = 1'b1;
            err_d    = 1'b1;
            result_d = '0;
            zero_d   = 1'b0;
            cout_d   = 1'b0;
            ovf_d    = 1'b0;
          end
        end
      end
      S_RUN: begin
        result_d = res_shift;
        carry_d  = alu_cout;
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          // Flags are finalised on the last bit so they are valid together with done
          cout_d  = alu_cout;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
          if (is_slt) begin
            result_d = WIDTH'(slt_bit);
            zero_d   = ~slt_bit;
            ovf_d    = 1'b0;
          end else begin
            zero_d = ~|res_shift;
            ovf_d  = is_addsub & msb_ovf;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
